main_top: RTL and testbench

- Top-level of the register-bank/ALU exercise.
- Holds a small register bank and feeds two fixed source registers into an 8-function ALU selected by a 3-bit opcode.
- Writes the ALU result back into a fixed destination register every clock and exposes it with status flags.
- Self-contained top: the only driven inputs are clock, reset and opcode.

---
 rtl/main_top.sv | 103 ++++++++++
 tb/tb_main_top.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/main_top.sv
// Register bank feeding a fixed-operand 8-function ALU; the result is written back
// into one destination register every clock and exposed with registered flags.
module main_top #(
    parameter int WIDTH = 32,
    parameter int NREG  = 8,
    parameter int SRC_A = 1,
    parameter int SRC_B = 2,
    parameter int DST   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       opcode,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero_flag,
    output logic             carry_flag
);

    localparam int IDXW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [IDXW-1:0] A_IDX = IDXW'(SRC_A);
    localparam logic [IDXW-1:0] B_IDX = IDXW'(SRC_B);
    localparam logic [IDXW-1:0] D_IDX = IDXW'(DST);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOR = 3'b101,
        OP_SLL = 3'b110,
        OP_SRL = 3'b111
    } op_e;

    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;

    logic [WIDTH-1:0] opa, opb, result;
    logic [WIDTH:0]   sum;
    logic             carry;
    op_e              op;

    always_comb begin
        opa    = regs_q[A_IDX];
        opb    = regs_q[B_IDX];
        op     = op_e'(opcode);
        sum    = {1'b0, opa} + {1'b0, opb};
        result = '0;
        carry  = 1'b0;
        unique case (op)
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            OP_SUB: begin
                result = opa - opb;
                carry  = (opa < opb);
            end
            OP_AND: result = opa & opb;
            OP_OR:  result = opa | opb;
            OP_XOR: result = opa ^ opb;
            OP_NOR: result = ~(opa | opb);
            OP_SLL: result = opa << opb[4:0];
            OP_SRL: result = opa >> opb[4:0];
            default: result = '0;
        endcase
    end

    // Every register recirculates; only the destination takes the new result,
    // so a source that aliases DST is read with its pre-edge value.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
        end
        regs_d[D_IDX] = result;
        zero_d        = (result == '0);
        carry_d       = carry;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            regs_q[A_IDX] <= WIDTH'(12);
            regs_q[B_IDX] <= WIDTH'(5);
            zero_q        <= 1'b0;
            carry_q       <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    assign alu_out    = regs_q[D_IDX];
    assign zero_flag  = zero_q;
    assign carry_flag = carry_q;

endmodule

// File: tb/tb_main_top.sv
// Directed bench for main_top: opcode sweep from a vector table, async reset,
// mid-cycle opcode changes, and two aliased-register parameter variants.
module tb_main_top;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  opcode, op_acc, op_sub;
    logic [31:0] alu_out, acc_out, sub_out;
    logic        zero_flag, carry_flag, acc_zero, acc_carry, sub_zero, sub_carry;

    int total = 0;
    int bad   = 0;

    always #10 clk = ~clk;

    main_top u_dut (
        .clk(clk), .rst(rst), .opcode(opcode),
        .alu_out(alu_out), .zero_flag(zero_flag), .carry_flag(carry_flag)
    );

    // B aliases the destination: R2 accumulates A every edge under ADD.
    main_top #(.SRC_B(2), .DST(2)) u_acc (
        .clk(clk), .rst(rst), .opcode(op_acc),
        .alu_out(acc_out), .zero_flag(acc_zero), .carry_flag(acc_carry)
    );

    // A aliases the destination: R1 decrements by 5 under SUB and eventually borrows.
    main_top #(.SRC_A(1), .DST(1)) u_sub (
        .clk(clk), .rst(rst), .opcode(op_sub),
        .alu_out(sub_out), .zero_flag(sub_zero), .carry_flag(sub_carry)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] res;
        logic        z;
        logic        c;
    } vec_t;

    vec_t vecs[8];

    logic [31:0] prev, acc_exp, sub_exp, sub_nxt;
    logic        sub_c;

    initial begin
        vecs[0] = '{3'b000, 32'h0000_0011, 1'b0, 1'b0};
        vecs[1] = '{3'b001, 32'h0000_0007, 1'b0, 1'b0};
        vecs[2] = '{3'b010, 32'h0000_0004, 1'b0, 1'b0};
        vecs[3] = '{3'b011, 32'h0000_000D, 1'b0, 1'b0};
        vecs[4] = '{3'b100, 32'h0000_0009, 1'b0, 1'b0};
        vecs[5] = '{3'b101, 32'hFFFF_FFF2, 1'b0, 1'b0};
        vecs[6] = '{3'b110, 32'h0000_0180, 1'b0, 1'b0};
        vecs[7] = '{3'b111, 32'h0000_0000, 1'b1, 1'b0};

        rst    = 1'b0;
        opcode = 3'b000;
        op_acc = 3'b000;
        op_sub = 3'b001;
        repeat (2) @(posedge clk);
        #1;
        check("reset alu_out", alu_out, 32'h0);
        check("reset zero", {31'b0, zero_flag}, 32'h0);
        check("reset carry", {31'b0, carry_flag}, 32'h0);
        check("reset acc R2", acc_out, 32'd5);
        check("reset sub R1", sub_out, 32'd12);

        @(negedge clk);
        rst     = 1'b1;
        prev    = 32'h0;
        acc_exp = 32'd5;
        sub_exp = 32'd12;
        for (int i = 0; i < 8; i++) begin
            opcode = vecs[i].op;
            #1;
            check($sformatf("no comb path op%0d", i), alu_out, prev);
            @(posedge clk);
            #1;
            check($sformatf("result op%0d", i), alu_out, vecs[i].res);
            check($sformatf("zero op%0d", i), {31'b0, zero_flag}, {31'b0, vecs[i].z});
            check($sformatf("carry op%0d", i), {31'b0, carry_flag}, {31'b0, vecs[i].c});
            acc_exp = acc_exp + 32'd12;
            check($sformatf("acc edge%0d", i + 1), acc_out, acc_exp);
            sub_c   = (sub_exp < 32'd5);
            sub_nxt = sub_exp - 32'd5;
            sub_exp = sub_nxt;
            check($sformatf("sub edge%0d", i + 1), sub_out, sub_exp);
            check($sformatf("borrow edge%0d", i + 1), {31'b0, sub_carry}, {31'b0, sub_c});
            prev = vecs[i].res;
            @(negedge clk);
        end

        // Zero flag is 1 here; an async reset between edges must clear it at once.
        @(posedge clk);
        #5;
        rst = 1'b0;
        #1;
        check("async rst alu_out", alu_out, 32'h0);
        check("async rst zero", {31'b0, zero_flag}, 32'h0);
        check("async rst acc", acc_out, 32'd5);
        check("async rst sub", sub_out, 32'd12);
        @(posedge clk);
        #1;
        check("held in reset", alu_out, 32'h0);

        // Only the opcode present at the edge matters.
        @(negedge clk);
        rst    = 1'b1;
        opcode = 3'b010;
        #3;
        opcode = 3'b110;
        @(posedge clk);
        #1;
        check("late opcode wins", alu_out, 32'h0000_0180);
        check("first acc after rst", acc_out, 32'd17);
        @(negedge clk);
        opcode = 3'b000;
        @(posedge clk);
        #1;
        check("add after shift", alu_out, 32'h0000_0011);
        check("acc second edge", acc_out, 32'd29);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
